// File: rtl/addr_sel_reg.sv
// rtl/addr_sel_reg.sv - memory address source select register with alignment checking
// Latches one of N_SRC address sources and holds it for a request/ready handshake.
module addr_sel_reg #(
  parameter int WIDTH = 32,
  parameter int N_SRC = 5,
  parameter int SEL_W = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_SRC*WIDTH-1:0] src_in,
  input  logic [1:0]             size,
  input  logic                   start,
  input  logic                   mem_ready,
  input  logic                   fault_clr,
  output logic [WIDTH-1:0]       addr_out,
  output logic                   mem_req,
  output logic                   busy,
  output logic                   done,
  output logic                   fault,
  output logic [1:0]             fault_cause,
  output logic [WIDTH-1:0]       fault_addr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REQ   = 2'b01,
    ST_FAULT = 2'b10
  } state_t;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_SEL   = 2'b01;
  localparam logic [1:0] CAUSE_ALIGN = 2'b10;

  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam logic [SEL_W:0] N_SRC_L = (SEL_W+1)'(N_SRC);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   addr_d;
  logic               done_d;
  logic               fault_d;
  logic [1:0]         cause_d;
  logic [WIDTH-1:0]   faddr_d;

  logic [WIDTH-1:0]   mux_val;
  logic               sel_valid;
  logic               misaligned;
  logic               start_ok;

  // Out-of-range selects fall through to zero; sel_valid gates their use.
  always_comb begin
    mux_val = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (sel == SEL_W'(k)) begin
        mux_val = src_in[k*WIDTH +: WIDTH];
      end
    end
  end

  assign sel_valid = ({1'b0, sel} < N_SRC_L);

  // Size 11 is treated as a word access.
  always_comb begin
    case (size)
      SZ_HALF: misaligned = mux_val[0];
      SZ_BYTE: misaligned = 1'b0;
      default: misaligned = |mux_val[1:0];
    endcase
  end

  assign start_ok = start && !fault && !fault_clr;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_out;
    done_d  = 1'b0;
    fault_d = fault;
    cause_d = fault_cause;
    faddr_d = fault_addr;

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          if (!sel_valid) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
            cause_d = CAUSE_SEL;
            faddr_d = '0;
          end else if (misaligned) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
            cause_d = CAUSE_ALIGN;
            faddr_d = mux_val;
          end else begin
            state_d = ST_REQ;
            addr_d  = mux_val;
          end
        end
      end
      ST_REQ: begin
        if (mem_ready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_FAULT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Clearing the sticky fault never touches state or the latched address.
    if (fault_clr) begin
      fault_d = 1'b0;
      cause_d = CAUSE_NONE;
      faddr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_out    <= '0;
      done        <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= CAUSE_NONE;
      fault_addr  <= '0;
    end else begin
      state_q     <= state_d;
      addr_out    <= addr_d;
      done        <= done_d;
      fault       <= fault_d;
      fault_cause <= cause_d;
      fault_addr  <= faddr_d;
    end
  end

  assign mem_req = (state_q == ST_REQ);
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_addr_sel_reg.sv
// tb/tb_addr_sel_reg.sv - scoreboard bench for addr_sel_reg
// Driver pushes predicted outcomes; a negedge monitor pops and compares.
module tb_addr_sel_reg;

  localparam int W  = 32;
  localparam int N  = 5;
  localparam int SW = 3;
  localparam int W2 = 16;
  localparam int N2 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, start, mem_ready, fault_clr;
  logic [SW-1:0]   sel;
  logic [1:0]      size;
  logic [N*W-1:0]  src_in;
  logic [W-1:0]    addr_out, fault_addr;
  logic            mem_req, busy, done, fault;
  logic [1:0]      fault_cause;

  logic            start2, mem_ready2, fault_clr2;
  logic [SW-1:0]   sel2;
  logic [1:0]      size2;
  logic [N2*W2-1:0] src2;
  logic [W2-1:0]   addr2, faddr2;
  logic            mem_req2, busy2, done2, fault2;
  logic [1:0]      cause2;

  addr_sel_reg #(.WIDTH(W), .N_SRC(N), .SEL_W(SW)) dut (
    .clk(clk), .reset(reset), .sel(sel), .src_in(src_in), .size(size),
    .start(start), .mem_ready(mem_ready), .fault_clr(fault_clr),
    .addr_out(addr_out), .mem_req(mem_req), .busy(busy), .done(done),
    .fault(fault), .fault_cause(fault_cause), .fault_addr(fault_addr)
  );

  addr_sel_reg #(.WIDTH(W2), .N_SRC(N2), .SEL_W(SW)) dut2 (
    .clk(clk), .reset(reset), .sel(sel2), .src_in(src2), .size(size2),
    .start(start2), .mem_ready(mem_ready2), .fault_clr(fault_clr2),
    .addr_out(addr2), .mem_req(mem_req2), .busy(busy2), .done(done2),
    .fault(fault2), .fault_cause(cause2), .fault_addr(faddr2)
  );

  typedef struct {
    int          kind;   // 0 ok, 1 invalid sel, 2 misaligned
    logic [31:0] addr;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_h;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] last_ok = '0;
  bit          model_fault = 0;
  logic [1:0]  model_cause = '0;
  logic [31:0] model_faddr = '0;
  bit          mon_en = 0;
  bit          fault_prev = 0;
  bit          hok;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic exp_t predict(input int s, input int sz, input logic [31:0] v);
    exp_t e;
    e.addr = '0;
    e.cyc  = 0;
    if (s >= N) begin
      e.kind = 1;
    end else if ((sz == 0 || sz == 3) && (v % 4 != 0)) begin
      e.kind = 2;
      e.addr = v;
    end else if (sz == 1 && (v % 2 != 0)) begin
      e.kind = 2;
      e.addr = v;
    end else begin
      e.kind = 0;
      e.addr = v;
    end
    return e;
  endfunction

  function automatic logic [N*W-1:0] rand_src();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = $urandom;
    return r;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (done) begin
        chk("done_expected", 64'(exp_q.size() > 0), 1);
        chk("done_busy", busy, 0);
        if (exp_q.size() > 0) begin
          mon_h = exp_q.pop_front();
          chk("done_kind", mon_h.kind, 0);
          chk("done_addr", addr_out, mon_h.addr);
          chk("done_cycle", cyc, mon_h.cyc);
          last_ok = mon_h.addr;
        end
      end
      if (fault && !fault_prev) begin
        chk("fault_expected", 64'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_h = exp_q.pop_front();
          chk("fault_cause_evt", fault_cause, (mon_h.kind == 1) ? 2'b01 : 2'b10);
          chk("fault_addr_evt", fault_addr, mon_h.addr);
        end
      end
      fault_prev = fault;
      hok = (exp_q.size() > 0) && (exp_q[0].kind == 0);
      chk("mem_req", mem_req, hok);
      chk("addr_out", addr_out, hok ? exp_q[0].addr : last_ok);
      chk("fault_flag", fault, model_fault);
      chk("fault_cause", fault_cause, model_cause);
      chk("fault_addr", fault_addr, model_faddr);
      if (mem_req) chk("busy_in_req", busy, 1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // k < 0 leaves the request outstanding
  task automatic issue(input int s, input int sz, input logic [N*W-1:0] srcs,
                       input int k, input bit noise);
    exp_t        e;
    logic [31:0] v;
    sel    = SW'(s);
    size   = 2'(sz);
    src_in = srcs;
    start  = 1'b1;
    step();
    start = 1'b0;
    if (model_fault) return;
    if (s < N) v = srcs[s*W +: W];
    else       v = '0;
    e = predict(s, sz, v);
    e.cyc = cyc + k + 1;
    exp_q.push_back(e);
    if (e.kind != 0) begin
      model_fault = 1;
      model_cause = (e.kind == 1) ? 2'b01 : 2'b10;
      model_faddr = e.addr;
      step();
    end else if (k >= 0) begin
      repeat (k) begin
        if (noise) begin
          sel    = SW'($urandom);
          size   = 2'($urandom);
          src_in = rand_src();
          start  = 1'($urandom);
        end
        step();
      end
      start     = 1'b0;
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      step();
    end
  endtask

  task automatic clr(input bit with_start);
    fault_clr = 1'b1;
    start     = with_start;
    sel       = 3'd0;
    size      = 2'b10;
    step();
    fault_clr   = 1'b0;
    start       = 1'b0;
    model_fault = 0;
    model_cause = '0;
    model_faddr = '0;
  endtask

  task automatic do_reset(input bit with_start);
    start = with_start;
    sel   = 3'd2;
    reset = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b0;
    exp_q.delete();
    last_ok     = '0;
    model_fault = 0;
    model_cause = '0;
    model_faddr = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [N*W-1:0] s;
    reset = 1'b1; start = 1'b0; mem_ready = 1'b0; fault_clr = 1'b0;
    sel = '0; size = '0; src_in = '0;
    start2 = 1'b0; mem_ready2 = 1'b0; fault_clr2 = 1'b0;
    sel2 = '0; size2 = '0; src2 = '0;
    repeat (2) step();
    chk("rst_addr", addr_out, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fault", fault, 0);
    chk("rst_cause", fault_cause, 0);
    chk("rst_faddr", fault_addr, 0);
    reset  = 1'b0;
    mon_en = 1;

    s = '0;
    s[2*W +: W] = 32'h0000_1004;
    issue(2, 0, s, 0, 0);

    s[0 +: W] = 32'h0000_0006;
    issue(0, 0, s, 0, 0);
    clr(0);
    issue(0, 1, s, 1, 0);

    issue(7, 0, s, 0, 0);
    issue(2, 0, s, 0, 0);
    clr(1);
    issue(2, 0, s, 2, 0);

    s[3*W +: W] = 32'h0000_2000;
    issue(3, 0, s, 10, 1);

    for (int t = 0; t < 80; t++) begin
      if (model_fault) begin
        case ($urandom % 3)
          0:       issue($urandom_range(0, 7), $urandom % 4, rand_src(), 0, 0);
          1:       clr(1);
          default: clr(0);
        endcase
      end else begin
        issue($urandom_range(0, 7), $urandom % 4, rand_src(), $urandom % 6, 1'($urandom));
      end
      if ($urandom % 4 == 0) begin
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
      end
    end

    if (model_fault) clr(0);
    s[2*W +: W] = 32'h0000_3008;
    issue(2, 0, s, -1, 0);
    repeat (3) step();
    do_reset(0);
    chk("rreq_done", done, 0);
    chk("rreq_mem_req", mem_req, 0);
    chk("rreq_busy", busy, 0);
    chk("rreq_addr", addr_out, 0);
    step();
    chk("rreq_done_next", done, 0);

    issue(6, 0, s, 0, 0);
    do_reset(1);
    chk("rst_start_busy", busy, 0);
    chk("rst_start_fault", fault, 0);
    repeat (3) step();
    chk("queue_drained", exp_q.size(), 0);

    src2 = '0;
    src2[7*W2 +: W2] = 16'h1004;
    sel2 = 3'd7; size2 = 2'b00; start2 = 1'b1;
    step();
    start2 = 1'b0;
    chk("p_mem_req", mem_req2, 1);
    chk("p_addr", addr2, 16'h1004);
    mem_ready2 = 1'b1;
    step();
    mem_ready2 = 1'b0;
    chk("p_done", done2, 1);
    chk("p_mem_req_off", mem_req2, 0);
    step();
    chk("p_done_once", done2, 0);
    chk("p_busy", busy2, 0);
    chk("p_addr_hold", addr2, 16'h1004);
    src2[7*W2 +: W2] = 16'h1006;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    chk("p_fault", fault2, 1);
    chk("p_cause", cause2, 2'b10);
    chk("p_faddr", faddr2, 16'h1006);
    chk("p_addr_kept", addr2, 16'h1004);
    fault_clr2 = 1'b1;
    step();
    fault_clr2 = 1'b0;
    chk("p_clr", fault2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/addr_sel_reg.md
ADDR_SEL_REG -- requirements
Module: addr_sel_reg

Interface
REQ-001 Parameter WIDTH, default 32, address/data width of every source and of addr_out.
REQ-002 Parameter N_SRC, default 5, number of address sources, legal range 2..2**SEL_W.
REQ-003 Parameter SEL_W, default 3, width of sel.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 sel  in  SEL_W  source index; 0=PC, 1=exception vector, 2=ALU out, 3=result, 4=B at default N_SRC.
REQ-007 src_in  in  N_SRC*WIDTH  flattened sources; source k at bits [k*WIDTH +: WIDTH].
REQ-008 size  in  2  access size: 00 word, 01 halfword, 10 byte, 11 treated as word.
REQ-009 start  in  1  request to latch a new address; single-cycle strobe.
REQ-010 mem_ready  in  1  memory accepted the current request.
REQ-011 fault_clr  in  1  clears the sticky fault.
REQ-012 addr_out  out  WIDTH  registered memory address.
REQ-013 mem_req  out  1  request to memory, high in REQ state only.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 done  out  1  one-cycle pulse on request completion.
REQ-016 fault  out  1  sticky fault flag.
REQ-017 fault_cause  out  2  00 none, 01 invalid sel, 10 misaligned.
REQ-018 fault_addr  out  WIDTH  offending address; 0 for invalid sel.

Function
REQ-019 States: IDLE, REQ, FAULT; encoding free.
REQ-020 IDLE: start accepted only when fault=0 and fault_clr=0; otherwise start ignored.
REQ-021 On accepted start: mux value = src_in slice [sel]; sel>=N_SRC -> FAULT, cause 01, fault_addr 0, addr_out unchanged.
REQ-022 Alignment check on mux value: word needs bits[1:0]=00, halfword bit[0]=0, byte always aligned; violation -> FAULT, cause 10, fault_addr = mux value, addr_out unchanged.
REQ-023 Otherwise addr_out <= mux value and state -> REQ; mem_req high from the following cycle (1-cycle latency start -> mem_req).
REQ-024 REQ: addr_out and mem_req held stable; start ignored; mem_ready sampled only here.
REQ-025 REQ with mem_ready=1 at an edge -> IDLE, done=1 for exactly that next cycle, mem_req=0; minimum start-to-done latency 2 cycles.
REQ-026 REQ with mem_ready=0 -> stay in REQ indefinitely; no timeout.
REQ-027 FAULT: one cycle, then IDLE; fault, fault_cause, fault_addr stay set until fault_clr or reset; done not asserted.
REQ-028 fault_clr=1 in any state clears fault, fault_cause to 00, fault_addr to 0 next edge; does not alter state or addr_out.
REQ-029 fault_clr and start same cycle: clear wins, start dropped.
REQ-030 addr_out retains last successfully latched value after done; never changes outside REQ-023.
REQ-031 No latch inference: every output fully assigned in every state and every sel value.

Reset
REQ-032 reset=1 at an edge: state IDLE; addr_out, fault_addr 0; mem_req, busy, done, fault 0; fault_cause 00.
REQ-033 reset overrides all other inputs, including mid-REQ and same-cycle start; no done pulse is produced for an aborted request.

Verification
REQ-034 sel=2, src2=0x0000_1004, size=00, start; mem_ready=1 on 2nd cycle -> addr_out=0x0000_1004, mem_req high 1 cycle, done pulse cycle 3, busy low after.
REQ-035 sel=0, src0=0x0000_0006, size=00, start -> fault=1, cause=10, fault_addr=0x0000_0006, addr_out unchanged, no mem_req; same address with size=01 -> accepted.
REQ-036 sel=7 (N_SRC=5), start -> fault=1, cause=01, fault_addr=0; following start ignored until fault_clr pulse; start with fault_clr same cycle ignored.
REQ-037 start with mem_ready held 0 for 10 cycles, toggling sel/src and start meanwhile -> addr_out and mem_req stable; done exactly one cycle after mem_ready rises.
REQ-038 reset asserted while in REQ -> next cycle all outputs 0, state IDLE, no done; parameter sweep WIDTH=16, N_SRC=8, SEL_W=3 repeats REQ-034 with sel=7.
